// File: rtl/imm_extend_unit_if.sv
// imm_extend_unit_if: decode-side request and execute-side result handshake for the immediate generator
interface imm_extend_unit_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
);
  localparam int PFX_W = OUT_W - IN_W;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [IN_W-1:0]  imm_in;
  logic [PFX_W-1:0] pfx_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic             pfx_pending;
  modport master (
    output flush, in_valid, mode, imm_in, pfx_in, out_ready,
    input  in_ready, out_valid, imm_out, pfx_pending
  );
  modport slave (
    input  flush, in_valid, mode, imm_in, pfx_in, out_ready,
    output in_ready, out_valid, imm_out, pfx_pending
  );
endinterface

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered sign/zero/scaled immediate generator with prefix register for full-width immediates
module imm_extend_unit #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input logic            clk,
  input logic            rst,
  imm_extend_unit_if.slave bus
);
  localparam int PFX_W = OUT_W - IN_W;
  logic [PFX_W-1:0] pfx_q;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] res;
  logic             accept;
  logic             pfx_ld;
  logic             ext;
  assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign pfx_ld = accept && bus.mode == 2'b10;
  assign ext    = accept && bus.mode != 2'b10;
  // a pending prefix overrides the extension kind; scaling still applies in mode 11
  always_comb begin
    base = bus.pfx_pending    ? {pfx_q, bus.imm_in} :
           bus.mode == 2'b01  ? {{PFX_W{1'b0}}, bus.imm_in} :
                                {{PFX_W{bus.imm_in[IN_W-1]}}, bus.imm_in};
    res  = bus.mode == 2'b11 ? base << SHIFT : base;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pfx_q           <= '0;
      bus.pfx_pending <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.imm_out     <= '0;
    end else if (bus.flush) begin
      bus.pfx_pending <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else begin
      if (pfx_ld) begin
        pfx_q           <= bus.pfx_in;
        bus.pfx_pending <= 1'b1;
      end else if (ext) begin
        bus.pfx_pending <= 1'b0;
      end
      if (ext) begin
        bus.imm_out   <= res;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: scoreboard-driven self-checking bench for imm_extend_unit
module tb_imm_extend_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imm_extend_unit_if #(.IN_W(5), .OUT_W(16)) bus ();
  imm_extend_unit #(.IN_W(5), .OUT_W(16), .SHIFT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  function automatic logic [15:0] model(input logic [1:0] m, input logic [4:0] i);
    logic [15:0] b;
    b = (m == 2'b01) ? {11'd0, i} : 16'($signed(i));
    return (m == 2'b11) ? {b[14:0], 1'b0} : b;
  endfunction
  task automatic send(input logic [1:0] m, input logic [4:0] imm, input logic [10:0] pfx);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.imm_in = imm;
    bus.pfx_in = pfx;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output bit seen);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    seen = bus.out_valid;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imm_out !== 16'h0 || bus.pfx_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out_valid=%b imm_out=%h pfx_pending=%b required 0/0000/0", bus.out_valid, bus.imm_out, bus.pfx_pending);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_extend(input string name, input logic [1:0] m, input logic [4:0] imm, input logic [15:0] want);
    bit seen;
    logic [15:0] e;
    send(m, imm, 11'h0);
    exp_q.push_back(want);
    wait_out(seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || bus.imm_out !== e) begin
      failures++;
      $display("FAIL %s imm_out=%h valid=%b required=%h", name, bus.imm_out, seen, e);
    end
    checks++;
    if (bus.pfx_pending !== 1'b0) begin
      failures++;
      $display("FAIL %s_pfx pfx_pending=%b required=0", name, bus.pfx_pending);
    end
  endtask
  task automatic test_prefix(input string name, input logic [10:0] pfx, input logic [1:0] m, input logic [4:0] imm, input logic [15:0] want);
    bit seen;
    logic [15:0] e;
    repeat (2) @(negedge clk);
    send(2'b10, 5'd0, pfx);
    @(negedge clk);
    checks++;
    if (bus.pfx_pending !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_load pfx_pending=%b out_valid=%b required 1/0", name, bus.pfx_pending, bus.out_valid);
    end
    send(m, imm, 11'h0);
    exp_q.push_back(want);
    wait_out(seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || bus.imm_out !== e || bus.pfx_pending !== 1'b0) begin
      failures++;
      $display("FAIL %s imm_out=%h pfx_pending=%b required=%h/0", name, bus.imm_out, bus.pfx_pending, e);
    end
  endtask
  task automatic test_backpressure;
    logic [15:0] e;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    send(2'b00, 5'b00011, 11'h0);
    exp_q.push_back(16'h0003);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode = 2'b00;
    bus.imm_in = 5'b00100;
    exp_q.push_back(16'h0004);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.imm_out !== exp_q[0]) begin
      failures++;
      $display("FAIL bp_hold in_ready=%b out_valid=%b imm_out=%h required 0/1/%h", bus.in_ready, bus.out_valid, bus.imm_out, exp_q[0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== e) begin
      failures++;
      $display("FAIL bp_hold2 out_valid=%b imm_out=%h required 1/%h", bus.out_valid, bus.imm_out, e);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== e) begin
      failures++;
      $display("FAIL bp_second out_valid=%b imm_out=%h required 1/%h", bus.out_valid, bus.imm_out, e);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_no_dup out_valid=%b queued=%0d required 0/0", bus.out_valid, exp_q.size());
    end
  endtask
  task automatic test_back_to_back;
    logic [15:0] e;
    logic [1:0] m;
    logic [4:0] i;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 8) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.imm_out !== e) begin
          failures++;
          $display("FAIL b2b_%0d out_valid=%b imm_out=%h required 1/%h", k, bus.out_valid, bus.imm_out, e);
        end
      end
      if (k < 8) begin
        m = 2'($urandom_range(0, 2));
        if (m == 2'b10) m = 2'b11;
        i = 5'($urandom);
        bus.in_valid = 1'b1;
        bus.mode = m;
        bus.imm_in = i;
        exp_q.push_back(model(m, i));
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain out_valid=%b required=0", bus.out_valid);
    end
  endtask
  task automatic test_flush;
    bit seen;
    logic [15:0] e;
    repeat (2) @(negedge clk);
    send(2'b10, 5'd0, 11'h7FF);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode = 2'b00;
    bus.imm_in = 5'b01000;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready got=%b required=0", bus.in_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.pfx_pending !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_state pfx_pending=%b out_valid=%b required 0/0", bus.pfx_pending, bus.out_valid);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    exp_q.push_back(16'h0008);
    wait_out(seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || bus.imm_out !== e) begin
      failures++;
      $display("FAIL flush_pfx_discard imm_out=%h required=%h", bus.imm_out, e);
    end
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    send(2'b00, 5'd5, 11'h0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_out_valid got=%b required=0", bus.out_valid);
    end
  endtask
  task automatic test_async_reset;
    repeat (2) @(negedge clk);
    send(2'b10, 5'd0, 11'h123);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.pfx_pending !== 1'b0) begin
      failures++;
      $display("FAIL arst_pfx pfx_pending=%b required=0", bus.pfx_pending);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    send(2'b00, 5'd7, 11'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imm_out !== 16'h0) begin
      failures++;
      $display("FAIL arst_out out_valid=%b imm_out=%h required 0/0000", bus.out_valid, bus.imm_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    bus.imm_in = '0;
    bus.pfx_in = '0;
    bus.out_ready = 1'b1;
    test_reset;
    test_extend("sext_neg", 2'b00, 5'b11000, 16'hFFF8);
    test_extend("sext_pos", 2'b00, 5'b01000, 16'h0008);
    test_extend("zext", 2'b01, 5'b11000, 16'h0018);
    test_extend("scaled", 2'b11, 5'b11110, 16'hFFFC);
    test_prefix("pfx_sext", 11'h7A5, 2'b00, 5'b10011, 16'hF4B3);
    test_prefix("pfx_scaled", 11'h001, 2'b11, 5'b00001, 16'h0042);
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_extend("post_reset", 2'b00, 5'b00001, 16'h0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
